mem_stage_p: RTL and testbench

MEM_STAGE_P -- requirements
Module: mem_stage_p

---
 rtl/mem_stage_p.sv | 133 +++++++++++++
 tb/tb_mem_stage_p.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_p.sv
// MEM pipeline stage: byte-lane data memory, branch resolve, MEM/WB register.
// Accesses take WAIT_STATES+1 cycles; stall holds upstream and bubbles MEM/WB meanwhile.
module mem_stage_p #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [31:0] alu_res,
    input  logic [31:0] write_data,
    input  logic [4:0]  des_reg,
    input  logic        reg_write,
    output logic        stall,
    output logic        pc_src,
    output logic        misalign,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_res,
    output logic [4:0]  wb_des_reg
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] w_idx;
    logic        w_go;
    logic        w_commit;
    logic [31:0] w_old;
    logic [31:0] w_wdat;
    logic [31:0] w_new;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [3:0]  w_be;
    logic        w_unused_hi;

    assign w_idx       = alu_res[ADDR_W+1:2];
    assign w_unused_hi = ^alu_res[31:ADDR_W+2];

    assign pc_src   = in_valid & branch & (zero ^ branch_ne);
    assign misalign = in_valid & (mem_read | mem_write) &
                      (((size == 2'b01) & alu_res[0]) | (size[1] & (alu_res[1:0] != 2'b00)));
    assign w_go     = in_valid & (mem_read | mem_write) & ~misalign;
    assign stall    = (r_state == S_IDLE) ? (w_go && (WS != 4'd0)) : (r_cnt != 4'd1);
    assign w_commit = w_go & ~stall;

    // Old word feeds both the load path and the merge, so a read+write returns pre-write data.
    assign w_old   = r_mem[w_idx];
    assign w_shift = w_old >> {alu_res[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = alu_res[1] ? w_old[31:16] : w_old[15:0];

    always_comb begin
        w_be   = 4'b0000;
        w_wdat = write_data;
        w_load = w_old;
        case (size)
            2'b00: begin
                w_be[alu_res[1:0]] = 1'b1;
                w_wdat = {4{write_data[7:0]}};
                w_load = unsigned_ld ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_be   = alu_res[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{write_data[15:0]}};
                w_load = unsigned_ld ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: w_be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++)
            w_new[8*i +: 8] = w_be[i] ? w_wdat[8*i +: 8] : w_old[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_commit && mem_write)
            r_mem[w_idx] <= w_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go && (WS != 4'd0)) begin
                    r_state <= S_WAIT;
                    r_cnt   <= WS;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_read_data <= 32'd0;
            wb_alu_res   <= 32'd0;
            wb_des_reg   <= 5'd0;
        end else if (stall) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid     <= in_valid;
            wb_reg_write <= in_valid & reg_write & ~misalign;
            wb_read_data <= (w_go & mem_read) ? w_load : 32'd0;
            wb_alu_res   <= alu_res;
            wb_des_reg   <= des_reg;
        end
    end

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed bench: one instance with no wait states, one with three.
module tb_mem_stage_p;

    logic        clk = 1'b0;
    logic        rst0, rst3, v0, v3;
    logic        mem_read, mem_write, unsigned_ld, branch, branch_ne, zero, reg_write;
    logic [1:0]  size;
    logic [31:0] alu_res, write_data;
    logic [4:0]  des_reg;

    logic        stall0, pc_src0, misalign0, wb_valid0, wb_reg_write0;
    logic [31:0] wb_read_data0, wb_alu_res0;
    logic [4:0]  wb_des_reg0;
    logic        stall3, pc_src3, misalign3, wb_valid3, wb_reg_write3;
    logic [31:0] wb_read_data3, wb_alu_res3;
    logic [4:0]  wb_des_reg3;

    int n_chk = 0;
    int n_err = 0;
    logic stall_seen0 = 1'b0;

    always #5 clk = ~clk;

    mem_stage_p #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .unsigned_ld(unsigned_ld), .branch(branch), .branch_ne(branch_ne),
        .zero(zero), .alu_res(alu_res), .write_data(write_data), .des_reg(des_reg),
        .reg_write(reg_write), .stall(stall0), .pc_src(pc_src0), .misalign(misalign0),
        .wb_valid(wb_valid0), .wb_reg_write(wb_reg_write0), .wb_read_data(wb_read_data0),
        .wb_alu_res(wb_alu_res0), .wb_des_reg(wb_des_reg0)
    );

    mem_stage_p #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .unsigned_ld(unsigned_ld), .branch(branch), .branch_ne(branch_ne),
        .zero(zero), .alu_res(alu_res), .write_data(write_data), .des_reg(des_reg),
        .reg_write(reg_write), .stall(stall3), .pc_src(pc_src3), .misalign(misalign3),
        .wb_valid(wb_valid3), .wb_reg_write(wb_reg_write3), .wb_read_data(wb_read_data3),
        .wb_alu_res(wb_alu_res3), .wb_des_reg(wb_des_reg3)
    );

    always @(negedge clk) if (stall0 === 1'b1) stall_seen0 = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic rw,
                          input logic [4:0] dr);
        mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns;
        alu_res = a; write_data = wd; reg_write = rw; des_reg = dr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the current access on the 3-wait-state instance until it completes.
    task automatic hold3(input string tag);
        v3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check({tag, "_stall"}, stall3, 1);
            step();
            check({tag, "_bubble"}, wb_valid3, 0);
        end
        #1;
        check({tag, "_last_nostall"}, stall3, 0);
        step();
        v3 = 1'b0;
        check({tag, "_done_valid"}, wb_valid3, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1; v0 = 1'b0; v3 = 1'b0;
        branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
        set_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 5'd0);
        step();
        check("rst_wb_valid0", wb_valid0, 0);
        check("rst_wb_rdata0", wb_read_data0, 0);
        check("rst_stall0", stall0, 0);
        check("rst_wb_regw3", wb_reg_write3, 0);
        step();
        rst0 = 1'b0; rst3 = 1'b0;

        // No wait states: store then load
        v0 = 1'b1;
        set_in(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 5'd0);
        #1 check("sw_stall", stall0, 0);
        step();
        set_in(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5'd5);
        step();
        check("lw_data", wb_read_data0, 32'hDEADBEEF);
        check("lw_valid", wb_valid0, 1);
        check("lw_regw", wb_reg_write0, 1);
        check("lw_des", wb_des_reg0, 5);
        check("lw_alu", wb_alu_res0, 32'h10);

        set_in(0, 1, 2'b00, 0, 32'h13, 32'h12345680, 0, 5'd0);
        step();
        set_in(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 5'd6);
        step();
        check("lb_sext", wb_read_data0, 32'hFFFFFF80);
        set_in(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 5'd6);
        step();
        check("lbu_zext", wb_read_data0, 32'h00000080);
        set_in(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5'd6);
        step();
        check("lw_after_sb", wb_read_data0, 32'h80ADBEEF);

        set_in(0, 1, 2'b01, 0, 32'h12, 32'h7777A5C3, 0, 5'd0);
        step();
        set_in(1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 5'd2);
        step();
        check("lh_sext", wb_read_data0, 32'hFFFFA5C3);
        set_in(1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 5'd2);
        step();
        check("lhu_zext", wb_read_data0, 32'h0000BEEF);

        // Misaligned accesses
        set_in(1, 0, 2'b01, 0, 32'h11, 32'h0, 1, 5'd3);
        #1;
        check("lh_mis_flag", misalign0, 1);
        check("lh_mis_stall", stall0, 0);
        step();
        check("lh_mis_regw", wb_reg_write0, 0);
        check("lh_mis_valid", wb_valid0, 1);
        check("lh_mis_rdata", wb_read_data0, 0);
        set_in(0, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 0, 5'd0);
        #1 check("sw_mis_flag", misalign0, 1);
        step();
        set_in(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5'd4);
        step();
        check("sw_mis_nowrite", wb_read_data0, 32'hA5C3BEEF);

        set_in(1, 0, 2'b10, 0, 32'h1010, 32'h0, 1, 5'd4);
        step();
        check("lw_wrap", wb_read_data0, 32'hA5C3BEEF);

        set_in(1, 1, 2'b10, 0, 32'h10, 32'h55667788, 1, 5'd1);
        step();
        check("rw_old_data", wb_read_data0, 32'hA5C3BEEF);
        set_in(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5'd1);
        step();
        check("rw_new_data", wb_read_data0, 32'h55667788);

        set_in(0, 1, 2'b11, 0, 32'h14, 32'h11223344, 0, 5'd0);
        step();
        set_in(1, 0, 2'b11, 0, 32'h14, 32'h0, 1, 5'd8);
        step();
        check("size11_word", wb_read_data0, 32'h11223344);
        set_in(1, 0, 2'b00, 1, 32'h15, 32'h0, 1, 5'd8);
        step();
        check("lbu_lane1", wb_read_data0, 32'h00000033);

        // Branch resolve and non-memory pass-through
        set_in(0, 0, 2'b00, 0, 32'h1234, 32'h0, 1, 5'd7);
        branch = 1'b1; zero = 1'b1; branch_ne = 1'b0;
        #1 check("beq_taken", pc_src0, 1);
        branch_ne = 1'b1;
        #1 check("bne_zero", pc_src0, 0);
        zero = 1'b0;
        #1 check("bne_taken", pc_src0, 1);
        branch = 1'b0;
        #1 check("no_branch", pc_src0, 0);
        step();
        check("alu_pass", wb_alu_res0, 32'h1234);
        check("alu_rdata0", wb_read_data0, 0);
        check("alu_regw", wb_reg_write0, 1);
        check("alu_des", wb_des_reg0, 7);
        v0 = 1'b0;
        step();
        check("idle_valid0", wb_valid0, 0);
        check("ws0_never_stall", stall_seen0, 0);

        // Three wait states
        set_in(0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 5'd0);
        hold3("ws3_sw");
        set_in(1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 5'd9);
        hold3("ws3_lw");
        check("ws3_lw_data", wb_read_data3, 32'hCAFEF00D);
        check("ws3_lw_regw", wb_reg_write3, 1);
        check("ws3_lw_des", wb_des_reg3, 9);

        set_in(1, 0, 2'b01, 0, 32'h11, 32'h0, 1, 5'd3);
        v3 = 1'b1;
        #1;
        check("ws3_mis_stall", stall3, 0);
        check("ws3_mis_flag", misalign3, 1);
        step();
        v3 = 1'b0;
        check("ws3_mis_valid", wb_valid3, 1);
        check("ws3_mis_regw", wb_reg_write3, 0);

        // Reset in the second stall cycle aborts the store
        set_in(0, 1, 2'b10, 0, 32'h20, 32'h12345678, 0, 5'd0);
        v3 = 1'b1;
        #1 check("abort_stall0", stall3, 1);
        step();
        rst3 = 1'b1;
        #1;
        check("abort_wb_alu", wb_alu_res3, 0);
        check("abort_wb_des", wb_des_reg3, 0);
        check("abort_wb_valid", wb_valid3, 0);
        v3 = 1'b0;
        step();
        rst3 = 1'b0;
        #1 check("abort_idle_stall", stall3, 0);
        set_in(1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 5'd9);
        hold3("abort_lw");
        check("abort_old_value", wb_read_data3, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
